chip_select_6502_prog: RTL and testbench

Programmable chip-select generator for a 6502-style bus, and the successor to the fixed-map chip-select decoder.
- Generalises to NUM_CS windows, each with runtime-loaded base, mask and enable.
- Adds per-window wait-state insertion that holds RDY low.
- Sits between the CPU address bus and the peripheral/memory selects inside the TT user project.

---
 rtl/chip_select_6502_prog.sv | 211 +++++++++++++++++++++
 tb/tb_chip_select_6502_prog.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/chip_select_6502_prog.sv
// rtl/chip_select_6502_prog.sv - programmable chip-select generator with wait states for a 6502-style bus
//
// Purpose:
//   NUM_CS decode windows, each with runtime base/mask/enable/wait registers.
//   The lowest-index enabled window matching addr drives its active-low select
//   one clock after addr_valid. A nonzero wait count holds rdy low for exactly
//   that many cycles while the select stays asserted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (also clears config)
//   addr_valid      one-cycle bus-cycle start strobe qualifying addr/rw
//   addr, rw        CPU address, 1=read / 0=write
//   cfg_we          config write strobe
//   cfg_sel         window index being written (out-of-range ignored)
//   cfg_field       0=base, 1=mask, 2=ctrl (3 ignored)
//   cfg_data        config data; ctrl: [ADDR_W-1]=enable, [WAIT_W-1:0]=wait
//   cs_n            active-low chip selects, at most one low
//   rdy             CPU ready, low during wait states
//   hit, hit_idx    current cycle matched a window / which one
//   wp_fault        (CS_WRITE_PROTECT_EN only) one-cycle pulse on a blocked write
//
// Optional feature macro: CS_WRITE_PROTECT_EN
//   ctrl bit ADDR_W-2 becomes a per-window write-protect flag; writes hitting
//   a protected window keep cs_n deasserted, report hit, and pulse wp_fault.

module chip_select_6502_prog #(
  parameter int ADDR_W = 16,
  parameter int NUM_CS = 4,
  parameter int WAIT_W = 3,
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [1:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  output logic [NUM_CS-1:0] cs_n,
  output logic              rdy,
  output logic              hit,
  output logic [SEL_W-1:0]  hit_idx
`ifdef CS_WRITE_PROTECT_EN
  ,
  output logic              wp_fault
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                rdy_q, rdy_d;
  logic                hit_q, hit_d;
  logic [SEL_W-1:0]    hit_idx_q, hit_idx_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]   base_q [NUM_CS];
  logic [ADDR_W-1:0]   base_d [NUM_CS];
  logic [ADDR_W-1:0]   mask_q [NUM_CS];
  logic [ADDR_W-1:0]   mask_d [NUM_CS];
  logic [WAIT_W-1:0]   wait_q [NUM_CS];
  logic [WAIT_W-1:0]   wait_d [NUM_CS];
  logic [NUM_CS-1:0]   en_q, en_d;
  logic [NUM_CS-1:0]   wp_q, wp_d;
  logic                wp_fault_q, wp_fault_d;

  logic                match_found;
  logic [SEL_W-1:0]    match_idx;
  logic [WAIT_W-1:0]   match_wait;
  logic                match_wp;
  logic [NUM_CS-1:0]   match_cs_n;
  logic                decode;
  logic                unused_in;

`ifdef CS_WRITE_PROTECT_EN
  assign unused_in = ^cfg_data[ADDR_W-3:WAIT_W];
  assign wp_fault  = wp_fault_q;
`else
  assign unused_in = ^{cfg_data[ADDR_W-2:WAIT_W], rw, wp_q, wp_fault_q};
`endif

  // Configuration register file
  always_comb begin
    base_d = base_q;
    mask_d = mask_q;
    wait_d = wait_q;
    en_d   = en_q;
    wp_d   = wp_q;
    if (cfg_we) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (cfg_sel == SEL_W'(i)) begin
          case (cfg_field)
            2'd0: base_d[i] = cfg_data;
            2'd1: mask_d[i] = cfg_data;
            2'd2: begin
              en_d[i]   = cfg_data[ADDR_W-1];
              wait_d[i] = cfg_data[WAIT_W-1:0];
`ifdef CS_WRITE_PROTECT_EN
              wp_d[i]   = cfg_data[ADDR_W-2];
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Priority match: iterate downward so the lowest matching index is kept
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    match_wait  = '0;
    match_wp    = 1'b0;
    match_cs_n  = '1;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (en_q[i] && ((addr & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
        match_found = 1'b1;
        match_idx   = SEL_W'(i);
        match_wait  = wait_q[i];
        match_wp    = wp_q[i];
        match_cs_n  = '1;
        match_cs_n[i] = 1'b0;
      end
    end
  end

  // A new bus cycle is accepted only outside WAIT; strobes during a stall are dropped
  assign decode = addr_valid && (state_q != ST_WAIT);

  always_comb begin
    state_d    = ST_IDLE;
    cs_n_d     = '1;
    rdy_d      = 1'b1;
    hit_d      = 1'b0;
    hit_idx_d  = '0;
    cnt_d      = cnt_q;
    wp_fault_d = 1'b0;
    if (decode) begin
      hit_d     = match_found;
      hit_idx_d = match_idx;
      if (match_found) begin
        if (match_wp && !rw) begin
          wp_fault_d = 1'b1;
        end else begin
          cs_n_d = match_cs_n;
          if (match_wait != '0) begin
            state_d = ST_WAIT;
            rdy_d   = 1'b0;
            cnt_d   = match_wait;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end
    end else if (state_q == ST_WAIT) begin
      cs_n_d    = cs_n_q;
      hit_d     = hit_q;
      hit_idx_d = hit_idx_q;
      // Counter holds the number of low-rdy cycles still visible, including this one
      if (cnt_q == WAIT_W'(1)) begin
        state_d = ST_ACTIVE;
      end else begin
        state_d = ST_WAIT;
        rdy_d   = 1'b0;
        cnt_d   = cnt_q - WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cs_n_q     <= '1;
      rdy_q      <= 1'b1;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      cnt_q      <= '0;
      en_q       <= '0;
      wp_q       <= '0;
      wp_fault_q <= 1'b0;
      for (int i = 0; i < NUM_CS; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        wait_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      rdy_q      <= rdy_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      wp_q       <= wp_d;
      wp_fault_q <= wp_fault_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
      wait_q     <= wait_d;
    end
  end

  assign cs_n    = cs_n_q;
  assign rdy     = rdy_q;
  assign hit     = hit_q;
  assign hit_idx = hit_idx_q;

endmodule

// File: tb/tb_chip_select_6502_prog.sv
// tb/tb_chip_select_6502_prog.sv - scoreboard bench for chip_select_6502_prog

module tb_chip_select_6502_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_valid;
  logic [15:0] addr;
  logic        rw;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [1:0]  cfg_field;
  logic [15:0] cfg_data;
  logic [3:0]  cs_n;
  logic        rdy;
  logic        hit;
  logic [1:0]  hit_idx;
`ifdef CS_WRITE_PROTECT_EN
  logic        wp_fault;
`endif

  chip_select_6502_prog dut (
    .clk        (clk),
    .rst        (rst),
    .addr_valid (addr_valid),
    .addr       (addr),
    .rw         (rw),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .cs_n       (cs_n),
    .rdy        (rdy),
    .hit        (hit),
    .hit_idx    (hit_idx)
`ifdef CS_WRITE_PROTECT_EN
    ,
    .wp_fault   (wp_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] cs_n;
    logic       rdy;
    logic       hit;
    logic [1:0] idx;
    logic       wp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   next_id     = 0;

  // Push the expected post-edge outputs, let one edge pass, release strobes
  task automatic tick(input logic [3:0] e_cs, input logic e_rdy, input logic e_hit,
                      input logic [1:0] e_idx, input logic e_wp);
    exp_t e;
    e.id   = next_id;
    e.cs_n = e_cs;
    e.rdy  = e_rdy;
    e.hit  = e_hit;
    e.idx  = e_idx;
    e.wp   = e_wp;
    exp_q.push_back(e);
    next_id++;
    @(posedge clk);
    @(negedge clk);
    addr_valid = 1'b0;
    cfg_we     = 1'b0;
  endtask

  task automatic idle_tick();
    tick(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [1:0] field, input logic [15:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_field = field;
    cfg_data  = data;
    idle_tick();
  endtask

  task automatic access(input logic [15:0] a, input logic r);
    addr_valid = 1'b1;
    addr       = a;
    rw         = r;
  endtask

  // Monitor: outputs are presented every cycle, so compare once per edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        logic act_wp;
        e = exp_q.pop_front();
        vectors++;
`ifdef CS_WRITE_PROTECT_EN
        act_wp = wp_fault;
`else
        act_wp = 1'b0;
`endif
        if (cs_n !== e.cs_n || rdy !== e.rdy || hit !== e.hit || hit_idx !== e.idx || act_wp !== e.wp) begin
          miscompares++;
          $display("FAIL vec%0d: got cs_n=%b rdy=%b hit=%b idx=%0d wp=%b, want cs_n=%b rdy=%b hit=%b idx=%0d wp=%b",
                   e.id, cs_n, rdy, hit, hit_idx, act_wp, e.cs_n, e.rdy, e.hit, e.idx, e.wp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; addr_valid = 1'b0; addr = '0; rw = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_field = '0; cfg_data = '0;
    @(negedge clk);
    idle_tick();
    rst = 1'b0;

    // All windows disabled
    access(16'h1234, 1'b1); idle_tick();
    idle_tick();

    // Window 1: 0x8000/0xC000, no wait
    cfg(2'd1, 2'd0, 16'h8000);
    cfg(2'd1, 2'd1, 16'hC000);
    cfg(2'd1, 2'd2, 16'h8000);
    access(16'h9ABC, 1'b1); tick(4'b1101, 1'b1, 1'b1, 2'd1, 1'b0);
    idle_tick();
    // Field 3 is ignored: window 1 still decodes the same
    cfg(2'd1, 2'd3, 16'h0000);
    access(16'hBFFF, 1'b0); tick(4'b1101, 1'b1, 1'b1, 2'd1, 1'b0);
    access(16'h7FFF, 1'b1); idle_tick();

    // Window 0 matches all, window 2 at 0x2000/0xF000: lowest index wins
    cfg(2'd0, 2'd1, 16'h0000);
    cfg(2'd0, 2'd2, 16'h8000);
    cfg(2'd2, 2'd0, 16'h2000);
    cfg(2'd2, 2'd1, 16'hF000);
    cfg(2'd2, 2'd2, 16'h8000);
    access(16'h2010, 1'b1); tick(4'b1110, 1'b1, 1'b1, 2'd0, 1'b0);
    idle_tick();
    // Disable window 0; back-to-back accesses move cs_n without a gap
    cfg(2'd0, 2'd2, 16'h0000);
    access(16'h2010, 1'b1); tick(4'b1011, 1'b1, 1'b1, 2'd2, 1'b0);
    access(16'h9ABC, 1'b1); tick(4'b1101, 1'b1, 1'b1, 2'd1, 1'b0);
    access(16'h1234, 1'b1); idle_tick();
    idle_tick();

    // Window 3: 0x4000/0xF000, wait=3
    cfg(2'd3, 2'd0, 16'h4000);
    cfg(2'd3, 2'd1, 16'hF000);
    cfg(2'd3, 2'd2, 16'h8003);
    access(16'h4321, 1'b1); tick(4'b0111, 1'b0, 1'b1, 2'd3, 1'b0);
    // Stray strobe and a config write during the stall must not disturb it
    access(16'h9ABC, 1'b1);
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_field = 2'd2; cfg_data = 16'h8000;
    tick(4'b0111, 1'b0, 1'b1, 2'd3, 1'b0);
    tick(4'b0111, 1'b0, 1'b1, 2'd3, 1'b0);
    tick(4'b0111, 1'b1, 1'b1, 2'd3, 1'b0);
    idle_tick();
    // The wait=0 write now applies
    access(16'h4321, 1'b1); tick(4'b0111, 1'b1, 1'b1, 2'd3, 1'b0);
    idle_tick();

    // Reset during the 2nd wait cycle clears outputs and config
    cfg(2'd3, 2'd2, 16'h8003);
    access(16'h4321, 1'b1); tick(4'b0111, 1'b0, 1'b1, 2'd3, 1'b0);
    tick(4'b0111, 1'b0, 1'b1, 2'd3, 1'b0);
    rst = 1'b1; idle_tick();
    rst = 1'b0;
    access(16'h4321, 1'b1); idle_tick();
    access(16'h9ABC, 1'b1); idle_tick();

`ifdef CS_WRITE_PROTECT_EN
    cfg(2'd1, 2'd0, 16'h8000);
    cfg(2'd1, 2'd1, 16'hC000);
    cfg(2'd1, 2'd2, 16'hC000);
    access(16'h8000, 1'b0); tick(4'b1111, 1'b1, 1'b1, 2'd1, 1'b1);
    idle_tick();
    access(16'h8000, 1'b1); tick(4'b1101, 1'b1, 1'b1, 2'd1, 1'b0);
    idle_tick();
`endif

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
